// File: rtl/calc_key_controller_pkg.sv
// Shared constants, state encoding and operand-entry helper for the calculator key controller.
package calc_pkg;
  localparam int OPERAND_W = 8;
  localparam int RESULT_W  = 16;
  localparam int BCD_W     = 20;

  localparam logic [1:0] KEY_DIGIT = 2'b00;
  localparam logic [1:0] KEY_OP    = 2'b01;
  localparam logic [1:0] KEY_EQ    = 2'b10;
  localparam logic [1:0] KEY_CLR   = 2'b11;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_B,
    ST_EXEC,
    ST_CONVERT,
    ST_HOLD,
    ST_ERR
  } state_t;

  // acc*10+d at 12 bits: 255*10+9 = 2559 cannot wrap, so overflow is a plain compare.
  function automatic logic [11:0] next_operand(input logic [OPERAND_W-1:0] acc,
                                               input logic [3:0] digit);
    return ({4'd0, acc} * 12'd10) + {8'd0, digit};
  endfunction
endpackage

// File: rtl/calc_key_controller_if.sv
// Key-event input stream and result output stream of the calculator controller.
interface calc_key_controller_if;
  import calc_pkg::*;

  // Both streams: a transfer happens on a rising edge where valid and ready are
  // both high; the sender holds valid and its payload stable until that edge.
  logic                key_valid;
  logic                key_ready;
  logic [1:0]          key_type;
  logic [3:0]          key_value;
  logic                result_valid;
  logic                result_ready;
  logic [RESULT_W-1:0] result_bin;
  logic                result_neg;
  logic [BCD_W-1:0]    result_bcd;

  modport master (
    output key_valid, key_type, key_value, result_ready,
    input  key_ready, result_valid, result_bin, result_neg, result_bcd
  );

  modport slave (
    input  key_valid, key_type, key_value, result_ready,
    output key_ready, result_valid, result_bin, result_neg, result_bcd
  );
endinterface

// File: rtl/calc_key_controller_bin2bcd.sv
// Sequential 16-bit double-dabble converter: load on start, then 16 shift/add-3 edges.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RESULT_W-1:0] bin_in,
  output logic [BCD_W-1:0]    bcd_out,
  output logic                busy,
  output logic                done
);
  logic [BCD_W+RESULT_W-1:0] work;
  logic [BCD_W+RESULT_W-1:0] shifted;
  logic [BCD_W-1:0]          adj;
  logic [3:0]                iter;

  always_comb begin
    adj = work[BCD_W+RESULT_W-1:RESULT_W];
    for (int i = 0; i < 5; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    shifted = {adj[BCD_W-2:0], work[RESULT_W-1:0], 1'b0};
  end

  // done flags the edge that performs the last iteration, so bcd_out and the
  // controller's HOLD entry land on the same edge.
  assign done = busy && (iter == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      work    <= '0;
      iter    <= 4'd0;
      busy    <= 1'b0;
      bcd_out <= '0;
    end else if (start) begin
      work <= {{BCD_W{1'b0}}, bin_in};
      iter <= 4'd0;
      busy <= 1'b1;
    end else if (busy) begin
      work <= shifted;
      iter <= iter + 4'd1;
      if (iter == 4'd15) begin
        busy    <= 1'b0;
        bcd_out <= shifted[BCD_W+RESULT_W-1:RESULT_W];
      end
    end
  end
endmodule

// File: rtl/calc_key_controller.sv
// Calculator sequencing front end: operand entry, arithmetic-unit drive, result capture and BCD hold.
module calc_key_controller
  import calc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  calc_key_controller_if.slave bus,
  output logic [1:0]           signal,
  output logic [OPERAND_W-1:0] data_out_a,
  output logic [OPERAND_W-1:0] data_out_b,
  input  logic [RESULT_W-1:0]  data_in_result,
  output logic                 error,
  output state_t               state
);
  logic                 key_ready_q;
  logic                 result_valid_q;
  logic                 result_neg_q;
  logic [RESULT_W-1:0]  result_bin_q;
  logic                 key_fire;
  logic                 is_neg;
  logic [RESULT_W-1:0]  magnitude;
  logic [OPERAND_W-1:0] active;
  logic [11:0]          next_val;
  logic                 conv_start;
  logic                 conv_busy;
  logic                 conv_done;
  logic [BCD_W-1:0]     bcd;

  assign key_fire   = bus.key_valid && key_ready_q;
  assign is_neg     = (signal == OP_SUB) && data_in_result[RESULT_W-1];
  assign magnitude  = is_neg ? (~data_in_result + 16'd1) : data_in_result;
  assign active     = (state == ST_ENTER_B) ? data_out_b : data_out_a;
  assign next_val   = next_operand(active, bus.key_value);
  assign conv_start = (state == ST_EXEC);

  assign bus.key_ready    = key_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_neg   = result_neg_q;
  assign bus.result_bin   = result_bin_q;
  assign bus.result_bcd   = bcd;

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start   (conv_start),
    .bin_in  (magnitude),
    .bcd_out (bcd),
    .busy    (conv_busy),
    .done    (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_ENTER_A;
      key_ready_q    <= 1'b1;
      signal         <= OP_PASS;
      data_out_a     <= '0;
      data_out_b     <= '0;
      result_valid_q <= 1'b0;
      result_bin_q   <= '0;
      result_neg_q   <= 1'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        ST_ENTER_A, ST_ENTER_B: begin
          if (key_fire) begin
            case (bus.key_type)
              KEY_DIGIT: begin
                if (bus.key_value <= 4'd9) begin
                  if (next_val > 12'd255) begin
                    state <= ST_ERR;
                    error <= 1'b1;
                  end else if (state == ST_ENTER_A) begin
                    data_out_a <= next_val[OPERAND_W-1:0];
                  end else begin
                    data_out_b <= next_val[OPERAND_W-1:0];
                  end
                end
              end
              KEY_OP: begin
                signal <= bus.key_value[1:0];
                state  <= ST_ENTER_B;
              end
              KEY_EQ: begin
                if (state == ST_ENTER_A) signal <= OP_PASS;
                state       <= ST_EXEC;
                key_ready_q <= 1'b0;
              end
              default: begin
                data_out_a <= '0;
                data_out_b <= '0;
                signal     <= OP_PASS;
                state      <= ST_ENTER_A;
              end
            endcase
          end
        end
        ST_EXEC: begin
          result_bin_q <= magnitude;
          result_neg_q <= is_neg;
          state        <= ST_CONVERT;
        end
        ST_CONVERT: begin
          // A converter that is not running can never finish; do not wait on it.
          if (conv_done || !conv_busy) begin
            state          <= ST_HOLD;
            result_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (result_valid_q && bus.result_ready) begin
            state          <= ST_ENTER_A;
            result_valid_q <= 1'b0;
            key_ready_q    <= 1'b1;
            data_out_a     <= '0;
            data_out_b     <= '0;
            signal         <= OP_PASS;
          end
        end
        ST_ERR: begin
          if (key_fire && (bus.key_type == KEY_CLR)) begin
            state      <= ST_ENTER_A;
            error      <= 1'b0;
            data_out_a <= '0;
            data_out_b <= '0;
            signal     <= OP_PASS;
          end
        end
        default: state <= ST_ENTER_A;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_key_controller.sv
// Bench for calc_key_controller: directed test-plan cases plus random calculations against a decimal model.
module tb_calc_key_controller;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  signal;
  logic [7:0]  data_out_a;
  logic [7:0]  data_out_b;
  logic [15:0] data_in_result;
  logic        error;
  state_t      state;

  calc_key_controller_if bus();

  calc_key_controller dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .signal         (signal),
    .data_out_a     (data_out_a),
    .data_out_b     (data_out_b),
    .data_in_result (data_in_result),
    .error          (error),
    .state          (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // arithmetic unit the controller drives
  always_comb begin
    case (signal)
      2'b00:   data_in_result = {8'd0, data_out_a};
      2'b01:   data_in_result = {8'd0, data_out_a} + {8'd0, data_out_b};
      2'b10:   data_in_result = {8'd0, data_out_a} - {8'd0, data_out_b};
      default: data_in_result = {8'd0, data_out_a} * {8'd0, data_out_b};
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  int m_a, m_b, m_op;
  bit m_inb, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_inb = 0; m_err = 0;
  endtask

  task automatic check_reset_values();
    check("rst_state", 32'(state), 32'(ST_ENTER_A));
    check("rst_key_ready", 32'(bus.key_ready), 1);
    check("rst_signal", 32'(signal), 0);
    check("rst_a", 32'(data_out_a), 0);
    check("rst_b", 32'(data_out_b), 0);
    check("rst_valid", 32'(bus.result_valid), 0);
    check("rst_bin", 32'(bus.result_bin), 0);
    check("rst_bcd", 32'(bus.result_bcd), 0);
    check("rst_neg", 32'(bus.result_neg), 0);
    check("rst_error", 32'(error), 0);
  endtask

  // driver: present a key until the edge where it is accepted
  task automatic send_key(input logic [1:0] t, input logic [3:0] v);
    bit ok;
    ok = 0;
    bus.key_valid = 1'b1;
    bus.key_type  = t;
    bus.key_value = v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.key_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    if (!ok) check("key_accept_timeout", 0, 1);
  endtask

  task automatic press(input logic [1:0] t, input logic [3:0] v);
    int n;
    state_t exp_st;
    send_key(t, v);
    if (m_err) begin
      if (t == KEY_CLR) model_clear();
    end else begin
      case (t)
        KEY_DIGIT: begin
          if (v <= 9) begin
            n = (m_inb ? m_b : m_a) * 10 + int'(v);
            if (n > 255) m_err = 1;
            else if (m_inb) m_b = n;
            else m_a = n;
          end
        end
        KEY_OP: begin
          m_op  = int'(v[1:0]);
          m_inb = 1;
        end
        KEY_EQ: if (!m_inb) m_op = 0;
        default: model_clear();
      endcase
    end
    if (m_err) exp_st = ST_ERR;
    else if (t == KEY_EQ) exp_st = ST_EXEC;
    else exp_st = m_inb ? ST_ENTER_B : ST_ENTER_A;
    check("key_state", 32'(state), 32'(exp_st));
    check("key_ready_after_key", 32'(bus.key_ready), (exp_st == ST_EXEC) ? 0 : 1);
    check("operand_a", 32'(data_out_a), m_a);
    check("operand_b", 32'(data_out_b), m_b);
    check("signal", 32'(signal), m_op);
    check("error", 32'(error), 32'(m_err));
  endtask

  task automatic press_number(input int value);
    int digs[$];
    int x;
    x = value;
    do begin
      digs.push_front(x % 10);
      x = x / 10;
    end while (x > 0);
    foreach (digs[i]) begin
      if ($urandom_range(0, 5) == 0) press(KEY_DIGIT, 4'($urandom_range(10, 15)));
      press(KEY_DIGIT, 4'(digs[i]));
    end
  endtask

  task automatic run_calc(input int a, input int op, input bit use_op, input int b, input int hold);
    int r, mag, k;
    bit neg;
    logic [36:0] exp;
    press_number(a);
    if (use_op) begin
      if ($urandom_range(0, 3) == 0) press(KEY_OP, 4'($urandom_range(0, 15)));
      press(KEY_OP, 4'(op));
      press_number(b);
    end
    press(KEY_EQ, 4'd0);
    case (m_op)
      0:       r = m_a;
      1:       r = m_a + m_b;
      2:       r = m_a - m_b;
      default: r = m_a * m_b;
    endcase
    neg = (r < 0);
    mag = neg ? -r : r;
    exp_q.push_back({neg, 16'(mag), to_bcd(mag)});
    // cycle 1 is the one right after the equals edge; valid must show in cycle 18
    k = 1;
    while (!bus.result_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("valid_cycle", k, 18);
    exp = exp_q.pop_front();
    check("result_neg", 32'(bus.result_neg), 32'(exp[36]));
    check("result_bin", 32'(bus.result_bin), 32'(exp[35:20]));
    check("result_bcd", 32'(bus.result_bcd), 32'(exp[19:0]));
    check("hold_state", 32'(state), 32'(ST_HOLD));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.result_valid), 1);
      check("hold_key_ready", 32'(bus.key_ready), 0);
      check("hold_bin", 32'(bus.result_bin), 32'(exp[35:20]));
      check("hold_bcd", 32'(bus.result_bcd), 32'(exp[19:0]));
      check("hold_a", 32'(data_out_a), m_a);
      check("hold_b", 32'(data_out_b), m_b);
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.result_ready = 1'b0;
    model_clear();
    check("post_valid", 32'(bus.result_valid), 0);
    check("post_key_ready", 32'(bus.key_ready), 1);
    check("post_state", 32'(state), 32'(ST_ENTER_A));
    check("post_a", 32'(data_out_a), 0);
    check("post_signal", 32'(signal), 0);
    check("post_bin_kept", 32'(bus.result_bin), 32'(exp[35:20]));
    check("post_neg_kept", 32'(bus.result_neg), 32'(exp[36]));
  endtask

  initial begin
    rst              = 1'b1;
    bus.key_valid    = 1'b1;
    bus.key_type     = KEY_DIGIT;
    bus.key_value    = 4'd7;
    bus.result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    bus.key_valid    = 1'b0;
    bus.result_ready = 1'b0;
    rst              = 1'b0;
    model_clear();

    run_calc(12, 1, 1, 34, 0);
    run_calc(5, 2, 1, 9, 0);
    run_calc(255, 3, 1, 255, 0);
    run_calc(200, 2, 1, 13, 10);
    run_calc(77, 0, 0, 0, 1);

    // A overflow, keys swallowed in ERR, clear recovers
    press(KEY_DIGIT, 4'd2);
    press(KEY_DIGIT, 4'd5);
    press(KEY_DIGIT, 4'd6);
    press(KEY_DIGIT, 4'd3);
    press(KEY_EQ, 4'd0);
    press(KEY_OP, 4'd1);
    press(KEY_CLR, 4'd0);

    // B overflow
    press(KEY_DIGIT, 4'd1);
    press(KEY_OP, 4'd1);
    press(KEY_DIGIT, 4'd9);
    press(KEY_DIGIT, 4'd9);
    press(KEY_DIGIT, 4'd9);
    press(KEY_CLR, 4'd0);

    // clear from both entry states
    press(KEY_DIGIT, 4'd4);
    press(KEY_CLR, 4'd0);
    press(KEY_DIGIT, 4'd3);
    press(KEY_OP, 4'd3);
    press(KEY_DIGIT, 4'd4);
    press(KEY_CLR, 4'd0);

    // reset during conversion
    press(KEY_DIGIT, 4'd3);
    press(KEY_OP, 4'd1);
    press(KEY_DIGIT, 4'd4);
    press(KEY_EQ, 4'd0);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;
    model_clear();
    repeat (20) @(posedge clk);
    #1;
    check("aborted_valid", 32'(bus.result_valid), 0);
    check("aborted_bcd", 32'(bus.result_bcd), 0);
    run_calc(7, 1, 1, 1, 0);

    for (int i = 0; i < 20; i++) begin
      run_calc($urandom_range(0, 255), $urandom_range(0, 3), ($urandom_range(0, 4) != 0),
               $urandom_range(0, 255), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
